// File: rtl/contador_pkg.sv
// Shared types and constants for the Lab 2 up/down counter family.
package contador_pkg;

    localparam int unsigned CONTADOR_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } estado_t;

endpackage

// File: rtl/contador_ascendente.sv
// Up counter with run-time limit, start/stop control, preload, wrap pulse and sticky overflow.
// Optional saturation mode (hold at limit, DONE state) enabled by CONTADOR_ASC_SATURATE_EN.
module contador_ascendente
    import contador_pkg::*;
#(
    parameter int unsigned width = CONTADOR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [width-1:0] d,
    input  logic [width-1:0] limit,
    input  logic             clr_ovf,
    output logic [width-1:0] y,
    output logic             wrap,
    output logic             ovf,
    output logic             running
);

    estado_t          r_estado;
    estado_t          w_estado_next;
    logic             r_running;
    logic [width-1:0] r_y;
    logic [width-1:0] w_y_next;
    logic             r_wrap;
    logic             w_wrap_next;
    logic             r_ovf;
    logic             w_ovf_next;

    logic             w_at_limit;
    logic             w_run_step;
    logic [width-1:0] w_d_clamped;
    logic [width-1:0] w_y_inc;

    // A limit lowered below y mid-run still counts as reached.
    assign w_at_limit  = (r_y >= limit);
    assign w_run_step  = (r_estado == RUN) && !stop;
    assign w_d_clamped = (d > limit) ? limit : d;
    assign w_y_inc     = r_y + width'(1);

    // State register; running tracks the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado  <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_estado  <= w_estado_next;
            r_running <= (w_estado_next == RUN);
        end
    end

    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            IDLE, PAUSE: begin
                if (start && !stop) begin
                    w_estado_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_estado_next = PAUSE;
                end
`ifdef CONTADOR_ASC_SATURATE_EN
                else if (w_at_limit && !load) begin
                    w_estado_next = DONE;
                end
`endif
            end
`ifdef CONTADOR_ASC_SATURATE_EN
            DONE: begin
                if (start) begin
                    w_estado_next = RUN;
                end
            end
`endif
            default: w_estado_next = IDLE;
        endcase
    end

    // Datapath: load beats increment; a wrap sets ovf even when clr_ovf is high.
    always_comb begin
        w_y_next    = r_y;
        w_wrap_next = 1'b0;
        w_ovf_next  = r_ovf & ~clr_ovf;
        if (load) begin
            w_y_next = w_d_clamped;
        end else if (w_run_step) begin
            if (w_at_limit) begin
`ifdef CONTADOR_ASC_SATURATE_EN
                w_y_next = limit;
`else
                w_y_next    = '0;
                w_wrap_next = 1'b1;
                w_ovf_next  = 1'b1;
`endif
            end else begin
                w_y_next = w_y_inc;
`ifdef CONTADOR_ASC_SATURATE_EN
                w_wrap_next = (w_y_inc == limit);
`endif
            end
        end
`ifdef CONTADOR_ASC_SATURATE_EN
        else if ((r_estado == DONE) && start) begin
            w_y_next = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_y    <= w_y_next;
            r_wrap <= w_wrap_next;
            r_ovf  <= w_ovf_next;
        end
    end

    assign y       = r_y;
    assign wrap    = r_wrap;
    assign ovf     = r_ovf;
    assign running = r_running;

endmodule

// File: tb/tb_contador_ascendente.sv
// Scoreboard bench for contador_ascendente (width=4); saturation scenarios follow CONTADOR_ASC_SATURATE_EN.
module tb_contador_ascendente;

    logic       clk = 1'b0;
    logic       reset, start, stop, load, clr_ovf;
    logic [3:0] d, limit;
    logic [3:0] y;
    logic       wrap, ovf, running;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned ncyc = 0;
    logic exp_o;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  y;
        logic        w;
        logic        o;
        logic        r;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;

    contador_ascendente #(.width(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .d(d), .limit(limit), .clr_ovf(clr_ovf),
        .y(y), .wrap(wrap), .ovf(ovf), .running(running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Monitor: every expectation is due after a specific edge and is checked mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= ncyc) begin
            e = q.pop_front();
            n_tests++;
            if (e.cyc != ncyc || y !== e.y || wrap !== e.w || ovf !== e.o || running !== e.r) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got y=%0d wrap=%b ovf=%b running=%b, want y=%0d wrap=%b ovf=%b running=%b",
                         e.name, ncyc, y, wrap, ovf, running, e.y, e.w, e.o, e.r);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic st, input logic sp, input logic ld, input logic [3:0] dd,
                        input logic [3:0] lim, input logic clr, input logic rst,
                        input logic [3:0] ey, input logic ew, input logic eo, input logic er,
                        input string nm);
        exp_t x;
        start = st; stop = sp; load = ld; d = dd; limit = lim; clr_ovf = clr; reset = rst;
        x.cyc = ncyc + 1; x.y = ey; x.w = ew; x.o = eo; x.r = er; x.name = nm;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        step(0,0,0,0,15,0,1, 0,0,0,0, "reset_c1");
        step(0,0,0,0,15,0,1, 0,0,0,0, "reset_c2");
        step(1,0,0,0,15,0,0, 0,0,0,1, "start_edge");
        step(0,0,0,0,15,0,0, 1,0,0,1, "first_inc");
        step(0,0,0,0,15,0,0, 2,0,0,1, "second_inc");
        step(0,0,0,0,15,0,0, 3,0,0,1, "inc_to_3");
        step(0,1,0,0,15,0,0, 3,0,0,0, "stop_at_3");
        for (int i = 0; i < 3; i++) step(0,1,0,0,15,0,0, 3,0,0,0, "pause_hold");
        step(1,0,0,0,15,0,0, 3,0,0,1, "resume");
        step(0,0,0,0,15,0,0, 4,0,0,1, "resume_inc");
        step(1,1,0,0,15,0,0, 4,0,0,0, "start_stop_run");
        step(1,1,0,0,15,0,0, 4,0,0,0, "start_stop_pause");
        step(0,0,1,9,15,0,0, 9,0,0,0, "load_9");
        step(0,0,1,12,10,0,0, 10,0,0,0, "load_clamp");
        step(1,0,0,0,15,0,0, 10,0,0,1, "restart");
        for (int i = 0; i < 4; i++) step(0,0,0,0,15,0,0, 4'(11 + i),0,0,1, "run_to_14");
        step(0,0,1,3,14,0,0, 3,0,0,1, "load_no_wrap");
`ifndef CONTADOR_ASC_SATURATE_EN
        step(0,0,0,0,5,0,0, 4,0,0,1, "lim5_inc4");
        step(0,0,0,0,5,0,0, 5,0,0,1, "lim5_inc5");
        step(0,0,0,0,5,0,0, 0,1,1,1, "wrap");
        step(0,0,0,0,5,0,0, 1,0,1,1, "wrap_single");
        for (int i = 2; i <= 5; i++) step(0,0,0,0,5,0,0, 4'(i),0,1,1, "lim5_count");
        step(0,0,0,0,5,1,0, 0,1,1,1, "clr_vs_wrap");
        step(0,0,0,0,5,1,0, 1,0,0,1, "clr_ovf");
        step(0,0,0,0,5,0,0, 2,0,0,1, "after_clr");
        step(0,0,0,0,1,0,0, 0,1,1,1, "limit_lowered");
        step(0,0,0,0,0,0,0, 0,1,1,1, "limit_zero_a");
        step(0,0,0,0,0,0,0, 0,1,1,1, "limit_zero_b");
        step(0,0,0,0,15,0,0, 1,0,1,1, "after_limit0");
        exp_o = 1'b1;
`else
        step(0,0,0,0,5,0,0, 4,0,0,1, "sat_inc4");
        step(0,0,0,0,5,0,0, 5,1,0,1, "sat_reach");
        step(0,0,0,0,5,0,0, 5,0,0,0, "sat_done");
        step(0,1,0,0,5,0,0, 5,0,0,0, "done_ignores_stop");
        step(1,0,0,0,5,0,0, 0,0,0,1, "done_restart");
        step(0,0,0,0,15,0,0, 1,0,0,1, "done_restart_inc");
        exp_o = 1'b0;
`endif
        for (int i = 2; i <= 7; i++) step(0,0,0,0,15,0,0, 4'(i),0,exp_o,1, "run_to_7");
        step(1,0,1,9,15,0,1, 0,0,0,0, "reset_mid_run");
        step(0,0,0,0,15,0,0, 0,0,0,0, "idle_after_reset");
        step(0,0,0,0,15,0,0, 0,0,0,0, "idle_holds");
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
